riscv_crypto_sm4_seq: RTL
=========================

// Module: riscv_crypto_sm4_seq
// PURPOSE
//  Arbitrates NUM_REQ requesters onto one combinational SM4 byte-round unit (ssm4.ks/ssm4.ed).
//  Each request is a full 32-bit T/T' transform. The block issues four byte operations (bs=0..3),
//  feeding each result back as the next rs1, and returns the final word tagged with the requester id.
// PARAMETERS
//  NUM_REQ  2  number of requesters, 1..4
//  ID_W     2  width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  g_clk        in   1           system clock
//  g_rst        in   1           synchronous reset, active-high
//  req_valid    in   NUM_REQ     per-requester request valid
//  req_ready    out  NUM_REQ     per-requester accept, one-hot or zero
//  req_op_ks    in   NUM_REQ     1 = key-schedule op (ks), 0 = encrypt/decrypt op (ed)
//  req_rs1      in   32*NUM_REQ  accumulator input; requester i occupies [32*i+:32]
//  req_rs2      in   32*NUM_REQ  sbox input word; requester i occupies [32*i+:32]
//  rsp_valid    out  1           result valid
//  rsp_ready    in   1           consumer accepts result
//  rsp_id       out  ID_W        index of the granted requester
//  rsp_data     out  32          final T/T' result
//  fu_rs1       out  32          to FU rs1 (current accumulator)
//  fu_rs2       out  32          to FU rs2 (latched rs2)
//  fu_bs        out  2           to FU byte select
//  fu_op_ks     out  1           to FU op_ssm4_ks
//  fu_op_ed     out  1           to FU op_ssm4_ed
//  fu_result    in   32          from FU result, same cycle as the fu_* outputs
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, bs_cnt=0, acc=0, rs2_q=0, rsp_valid=0, req_ready=0, rsp_id=0,
//   rsp_data=0. fu_op_ks and fu_op_ed are both 0 whenever state != RUN.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: round-robin grant over req_valid, searching from rr_ptr upward with wrap.
//   req_ready[g]=1 combinationally for the grant g only. Handshake = valid & ready.
//   On handshake: latch acc=rs1[g], rs2_q=rs2[g], op_q=op_ks[g], id_q=g; set bs_cnt=0;
//   set rr_ptr = (g+1) mod NUM_REQ; go to RUN.
//   If no request is valid, stay in IDLE and leave rr_ptr unchanged.
//  RUN: drive fu_rs1=acc, fu_rs2=rs2_q, fu_bs=bs_cnt, fu_op_ks=op_q, fu_op_ed=~op_q.
//   Each cycle: acc<=fu_result, bs_cnt<=bs_cnt+1. After the bs=3 cycle go to DONE.
//  DONE: rsp_valid=1, rsp_data=acc, rsp_id=id_q. All three are held stable until rsp_ready.
//   On handshake go to IDLE. No new accept happens in the same cycle as the response handshake.
//  Latency: request accepted in cycle N, FU busy N+1..N+4, rsp_valid from N+5.
//   Minimum issue interval is 6 cycles.
//  req_ready stays 0 in RUN and DONE. A requester must hold valid and its data until accepted.
//  Simultaneous valids: exactly one grant per accept, no starvation.
//   Any requester is served within NUM_REQ grants.
//  rsp_ready held 0 indefinitely: the block stalls in DONE with outputs stable.
//  g_rst asserted in any state: the next edge returns to IDLE. The in-flight op is dropped with no response.
//  NUM_REQ=1: rr_ptr is constant 0.
//  All arithmetic is XOR within 32 bits. bs_cnt is 2 bits and wraps 3->0 only at RUN exit.
// STRUCTURE
//  Shared package riscv_crypto_pkg: FSM state encoding (SM4_SEQ_IDLE/RUN/DONE),
//   SM4_BYTES=4, SM4_BS_W=2.
//  One sub-module: riscv_crypto_rr_arb (NUM_REQ-wide round-robin arbiter: req, ptr -> one-hot gnt, idx).
//  The FU itself is instantiated outside; this block only drives its ports.
// TESTING (bench binds a real riscv_crypto_fu_ssm4 to the fu_* ports)
//  1 req0 ed, rs1=0x00000000, rs2=0x00000000 -> rsp_data=0x5B5B5B5B, rsp_id=0, rsp_valid at accept+5.
//  2 req1 ks, rs1=0x00000000, rs2=0x00000000 -> rsp_data=0x67676767, rsp_id=1;
//    same op with rs1=0xFFFFFFFF -> 0x98989898.
//  3 req0 and req1 held valid for 4 transactions from reset -> grant order 0,1,0,1.
//    Each response is correct for its own op. req_ready is never high for both.
//  4 rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable and no new accept.
//    Then rsp_ready=1 -> IDLE, and the next accept occurs one cycle later.
//  5 g_rst pulsed during RUN (bs_cnt=2) -> no response; all outputs at reset values next cycle.
//    The next request completes correctly.
//  6 Check each cycle: fu_bs sequence is 0,1,2,3 per op; exactly one of fu_op_ks/fu_op_ed is set only in RUN.

Source files
------------

// File: rtl/riscv_crypto_pkg.sv
// riscv_crypto_pkg: shared FSM encoding and SM4 byte-round constants
package riscv_crypto_pkg;
  typedef enum logic [1:0] {
    SM4_SEQ_IDLE,
    SM4_SEQ_RUN,
    SM4_SEQ_DONE
  } sm4_seq_state_t;
  localparam int SM4_BYTES = 4;
  localparam int SM4_BS_W = 2;
endpackage

// File: rtl/riscv_crypto_rr_arb.sv
// riscv_crypto_rr_arb: round-robin arbiter searching upward from ptr with wrap
module riscv_crypto_rr_arb #(
  parameter int N = 2,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  logic [2*N-1:0] rot;
  assign rot = {req, req} >> ptr;
  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) idx = IDX_W'((int'(ptr) + k) % N);
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/riscv_crypto_sm4_seq.sv
// riscv_crypto_sm4_seq: arbitrated four-pass sequencer over one SM4 byte-round unit
module riscv_crypto_sm4_seq
  import riscv_crypto_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W = 2
) (
  input  logic                  g_clk,
  input  logic                  g_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_op_ks,
  input  logic [32*NUM_REQ-1:0] req_rs1,
  input  logic [32*NUM_REQ-1:0] req_rs2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic [31:0]           fu_rs1,
  output logic [31:0]           fu_rs2,
  output logic [SM4_BS_W-1:0]   fu_bs,
  output logic                  fu_op_ks,
  output logic                  fu_op_ed,
  input  logic [31:0]           fu_result
);
  sm4_seq_state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, id_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [SM4_BS_W-1:0] bs_cnt;
  logic [31:0] acc, rs2_q, sel_rs1, sel_rs2;
  logic op_q, idle, run, done, accept;

  riscv_crypto_rr_arb #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gnt_idx)
  );

  assign idle = state == SM4_SEQ_IDLE;
  assign run = state == SM4_SEQ_RUN;
  assign done = state == SM4_SEQ_DONE;
  assign accept = idle && |req_valid;
  assign req_ready = idle ? gnt : '0;
  assign rsp_valid = done;
  assign rsp_data = done ? acc : '0;
  assign rsp_id = done ? id_q : '0;
  assign fu_rs1 = acc;
  assign fu_rs2 = rs2_q;
  assign fu_bs = bs_cnt;
  assign fu_op_ks = run && op_q;
  assign fu_op_ed = run && !op_q;

  always_comb begin
    sel_rs1 = '0;
    sel_rs2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_rs1 |= gnt[i] ? req_rs1[32*i +: 32] : '0;
      sel_rs2 |= gnt[i] ? req_rs2[32*i +: 32] : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = SM4_SEQ_RUN;
    else if (run && bs_cnt == SM4_BS_W'(SM4_BYTES - 1)) state_nxt = SM4_SEQ_DONE;
    else if (done && rsp_ready) state_nxt = SM4_SEQ_IDLE;
  end

  always_ff @(posedge g_clk)
    if (g_rst) state <= SM4_SEQ_IDLE;
    else state <= state_nxt;

  always_ff @(posedge g_clk)
    if (g_rst) begin
      rr_ptr <= '0;
      bs_cnt <= '0;
      acc <= '0;
      rs2_q <= '0;
      op_q <= 1'b0;
      id_q <= '0;
    end else if (accept) begin
      acc <= sel_rs1;
      rs2_q <= sel_rs2;
      op_q <= |(req_op_ks & gnt);
      id_q <= gnt_idx;
      bs_cnt <= '0;
      rr_ptr <= gnt_idx == ID_W'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end else if (run) begin
      acc <= fu_result;
      bs_cnt <= bs_cnt + 1'b1;
    end
endmodule
